// File: rtl/rv_fifo_pkg.sv
// rv_fifo_pkg: shared types package for ready/valid datapath blocks.
// Contents:
//   ARCH_WIDTH  default payload width used by ready/valid blocks
//   is_pow2()   elaboration-time helper for power-of-two parameter checks
package rv_fifo_pkg;

  localparam int ARCH_WIDTH = 32;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/rv_if.sv
// rv_if: ready/valid handshake bundle.
// Signals:
//   valid  producer -> consumer, data is meaningful
//   data   producer -> consumer, DW-bit payload
//   ready  consumer -> producer, beat can be taken
// Modports: TX (producer side), RX (consumer side).
interface rv_if #(
  parameter int DW = 32
) ();
  logic          valid;
  logic [DW-1:0] data;
  logic          ready;

  modport TX (output valid, output data, input ready);
  modport RX (input valid, input data, output ready);
endinterface

// File: rtl/rv_fifo_mem.sv
// rv_fifo_mem: DEPTH x DW register array, synchronous write, asynchronous read.
// Contents are never reset.
// Ports:
//   clk    clock
//   we     write enable
//   waddr  write index
//   wdata  write payload
//   raddr  read index
//   rdata  read payload (combinational from raddr)
module rv_fifo_mem #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rv_fifo.sv
// rv_fifo: single-clock ready/valid FIFO with occupancy and status flags.
// Build option: define RV_FIFO_BYPASS_EN to let a beat arriving at an empty
// FIFO pass straight from in to out in the same cycle when out is ready.
// Ports:
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset
//   flush        synchronous clear of all entries (wins over push/pop)
//   in           producer side (valid/data in, ready out)
//   out          consumer side (valid/data out, ready in)
//   count        occupancy 0..DEPTH
//   full, empty, almost_full  status flags decoded from count
module rv_fifo
  import rv_fifo_pkg::*;
#(
  parameter int DW       = ARCH_WIDTH,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  localparam int AW      = $clog2(DEPTH),
  localparam int PW      = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  rv_if.RX              in,
  rv_if.TX              out,
  output logic [PW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full
);

  if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_depth_chk
    $fatal(1, "rv_fifo: DEPTH must be a power of two and at least 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_af_chk
    $fatal(1, "rv_fifo: AF_LEVEL must lie in 1..DEPTH");
  end

  // Extra MSB on each pointer is the wrap bit: equal pointers mean empty,
  // equal index with differing wrap bits means full.
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [DW-1:0] rd_data;
  logic          push;
  logic          pop;

  assign empty       = (count == '0);
  assign full        = (count == PW'(DEPTH));
  assign almost_full = (count >= PW'(AF_LEVEL));

  // in.ready depends only on registered occupancy, never on out.ready.
  assign in.ready = !full;
  assign pop      = !empty && out.ready;

`ifdef RV_FIFO_BYPASS_EN
  logic bypass;
  // A bypassed beat is consumed directly and never touches storage.
  assign bypass    = empty && in.valid && out.ready;
  assign push      = in.valid && !full && !bypass;
  assign out.valid = !empty || in.valid;
  assign out.data  = empty ? in.data : rd_data;
`else
  assign push      = in.valid && !full;
  assign out.valid = !empty;
  assign out.data  = rd_data;
`endif

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
    end
  end

  rv_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (in.data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_rv_fifo.sv
module tb_rv_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;

  rv_if #(.DW(DW)) in_if ();
  rv_if #(.DW(DW)) out_if ();

  rv_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in          (in_if),
    .out         (out_if),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          flush;
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic [2:0]    e_count;
    logic          e_full;
    logic          e_empty;
    logic          e_af;
    logic          e_irdy;
    logic          e_ov;
    logic          chk_d;
    logic [DW-1:0] e_od;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic r, input logic f, input logic iv, input logic [DW-1:0] id,
                     input logic ordy, input int c, input logic chk_d, input logic [DW-1:0] od);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_count = 3'(c);
    v.e_full  = (c == DEPTH);
    v.e_empty = (c == 0);
    v.e_af    = (c >= DEPTH - 1);
    v.e_irdy  = (c != DEPTH);
    v.e_ov    = (c != 0);
    v.chk_d   = chk_d;
    v.e_od    = od;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_status(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    chk({p, ".count"}, DW'(count), DW'(v.e_count));
    chk({p, ".full"}, DW'(full), DW'(v.e_full));
    chk({p, ".empty"}, DW'(empty), DW'(v.e_empty));
    chk({p, ".almost_full"}, DW'(almost_full), DW'(v.e_af));
    chk({p, ".in_ready"}, DW'(in_if.ready), DW'(v.e_irdy));
    chk({p, ".out_valid"}, DW'(out_if.valid), DW'(v.e_ov));
    if (v.chk_d) chk({p, ".out_data"}, out_if.data, v.e_od);
  endtask

  localparam logic [DW-1:0] A = 32'hA0A0_0001, B = 32'hB0B0_0002, C = 32'hC0C0_0003;
  localparam logic [DW-1:0] D = 32'hD0D0_0004, E = 32'hE0E0_0005, F = 32'hF0F0_0006;
  localparam logic [DW-1:0] G = 32'h1234_0007, X = 32'h5555_0008, Y = 32'h6666_0009;
  localparam logic [DW-1:0] P1 = 32'h7000_0001, P2 = 32'h7000_0002, P3 = 32'h7000_0003;
  localparam logic [DW-1:0] Q = 32'h8888_000A, R = 32'h9999_000B;

  function automatic logic [DW-1:0] h(input int i);
    return 32'h4400_0000 + DW'(i);
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0;
    in_if.valid = 1'b0; in_if.data = '0; out_if.ready = 1'b0;
    repeat (2) @(posedge clk);

    // Each row: inputs for this cycle, outputs expected before its clock edge.
    add(1, 0, 0, '0, 0, 0, 0, '0);      // reset state
    add(0, 0, 1, A, 0, 0, 0, '0);       // first push right after reset
    add(0, 0, 1, B, 0, 1, 1, A);
    add(0, 0, 1, C, 0, 2, 1, A);
    add(0, 0, 1, D, 0, 3, 1, A);        // almost_full from count 3
    add(0, 0, 1, E, 0, 4, 1, A);        // full, E refused
    add(0, 0, 1, E, 1, 4, 1, A);        // pop A, in.ready stays low
    add(0, 0, 1, E, 0, 3, 1, B);        // in.ready back, E accepted
    add(0, 0, 0, '0, 1, 4, 1, B);
    add(0, 0, 0, '0, 1, 3, 1, C);
    add(0, 0, 0, '0, 1, 2, 1, D);
    add(0, 0, 0, '0, 1, 1, 1, E);
    add(0, 0, 0, '0, 1, 0, 0, '0);
    add(0, 0, 1, F, 0, 0, 0, '0);
    add(0, 0, 1, G, 0, 1, 1, F);
    for (int i = 0; i < 10; i++)        // steady push+pop at count 2, pointers wrap
      add(0, 0, 1, h(i), 1, 2, 1, (i == 0) ? F : (i == 1) ? G : h(i - 2));
    add(0, 0, 0, '0, 0, 2, 1, h(8));
    add(0, 0, 1, X, 0, 2, 1, h(8));
    add(0, 1, 1, Y, 1, 3, 1, h(8));     // flush beats push and pop
    add(0, 0, 0, '0, 0, 0, 0, '0);
    add(0, 0, 1, P1, 0, 0, 0, '0);
    add(0, 0, 1, P2, 0, 1, 1, P1);
    add(0, 0, 1, P3, 0, 2, 1, P1);
    add(1, 0, 1, Q, 1, 3, 1, P1);       // reset mid-stream
    add(0, 0, 1, R, 0, 0, 0, '0);
    add(0, 0, 0, '0, 0, 1, 1, R);
    add(0, 0, 0, '0, 1, 1, 1, R);
    add(0, 0, 0, '0, 0, 0, 0, '0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; flush = vecs[i].flush;
      in_if.valid = vecs[i].iv; in_if.data = vecs[i].id; out_if.ready = vecs[i].ordy;
      #1;
      check_status(i, vecs[i]);
    end

    // Empty FIFO, beat offered while consumer is ready.
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    in_if.valid = 1'b1; in_if.data = 32'hDEAD_BEEF; out_if.ready = 1'b1;
    #1;
`ifdef RV_FIFO_BYPASS_EN
    chk("byp.out_valid", DW'(out_if.valid), DW'(1'b1));
    chk("byp.out_data", out_if.data, 32'hDEAD_BEEF);
    chk("byp.count", DW'(count), DW'(0));
    @(negedge clk);
    in_if.valid = 1'b0; out_if.ready = 1'b0;
    #1;
    chk("byp.count_after", DW'(count), DW'(0));
    chk("byp.empty_after", DW'(empty), DW'(1'b1));
    chk("byp.valid_after", DW'(out_if.valid), DW'(1'b0));
`else
    chk("nobyp.out_valid", DW'(out_if.valid), DW'(1'b0));
    chk("nobyp.count", DW'(count), DW'(0));
    @(negedge clk);
    in_if.valid = 1'b0; out_if.ready = 1'b0;
    #1;
    chk("nobyp.count_after", DW'(count), DW'(1));
    chk("nobyp.valid_after", DW'(out_if.valid), DW'(1'b1));
    chk("nobyp.data_after", out_if.data, 32'hDEAD_BEEF);
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
